wave_reader: RTL and testbench
==============================

WAVE_READER -- requirements
Module: wave_reader

Interface
REQ-001 SHALL have parameter AMP_BITS, default 4, giving the width of the volume input.
REQ-002 SHALL have port clk_10k, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port address, input, 8 bits: unsigned phase index from the phase accumulator.
REQ-005 SHALL have port addr_valid, input, 1 bit: marks address, wave_sel, volume and mute as a new sample request.
REQ-006 SHALL have port wave_sel, input, 2 bits: waveform select; 00 sine, 01 square, 10 saw, 11 triangle.
REQ-007 SHALL have port volume, input, AMP_BITS bits: unsigned amplitude, 0 to 15.
REQ-008 SHALL have port mute, input, 1 bit: forces the output sample to zero.
REQ-009 SHALL have port sample, output, 8 bits: signed two's-complement output sample.
REQ-010 SHALL have port sample_valid, output, 1 bit: one-cycle pulse marking a new sample.
REQ-011 SHALL have port zero_cross, output, 1 bit: one-cycle pulse on a negative-to-non-negative output transition.

Function
REQ-012 SHALL run a 3-stage pipeline: capture, waveform, scale.
REQ-013 SHALL register address, wave_sel, volume and mute in the capture stage only on an edge where addr_valid=1; a change on these inputs at any other time SHALL NOT affect any output.
REQ-014 SHALL compute the waveform stage from captured values only.
- Sine: round(127*sin(2*pi*a/256)), range -127..127.
- Sine with a quarter-wave table is allowed if it is bit-exact.
REQ-015 SHALL produce square = +127 when a[7]=0, and -127 when a[7]=1.
REQ-016 SHALL produce saw = a - 128 as a signed value: a=0 gives -128; a=255 gives +127.
REQ-017 SHALL produce triangle = 2*f - 128, where f = a[6:0] when a[7]=0, else ~a[6:0]; range -128..+126.
REQ-018 SHALL compute the scale stage as the signed 12-bit product raw*volume, arithmetic-shifted right by 4 (floor), truncated to 8 bits; the result never overflows.
REQ-019 SHALL force the scale-stage result to 0 when the captured mute=1, or when volume=0.
REQ-020 SHALL assert sample_valid for exactly one cycle after edge t+2 for an addr_valid accepted at edge t, with sample updated on that same edge t+2.
REQ-021 SHALL accept addr_valid on every consecutive cycle with no stall; each request yields one output in order, throughput 1 sample per clock.
REQ-022 SHALL hold sample at its last value while no sample_valid is pending.
REQ-023 SHALL pulse zero_cross for one cycle, coincident with sample_valid, when the previous output sample was negative and the new one is >= 0.
REQ-024 SHALL NOT assert zero_cross for the first sample after reset.
REQ-025 SHALL handle the 8-bit address wrap 255 -> 0 with no special case; saw output steps from +127 to -128.

Reset
REQ-026 SHALL, while rst=1, immediately clear sample to 0, sample_valid to 0, zero_cross to 0, all stage valid flags, and the previous-sample sign record.
REQ-027 SHALL discard any request in flight when rst asserts mid-pipeline; no sample_valid is produced for it after reset releases.
REQ-028 SHALL allow an addr_valid on the first rising edge after rst deasserts to be accepted normally.

Verification
REQ-029 SHALL test: sine, volume=15, addr_valid at edge t with address 64 -> sample=119 after edge t+2, with sample_valid high for 1 cycle.
REQ-030 SHALL test: saw, volume=15, addresses 255 then 0 on consecutive cycles -> samples 119 then -120 on consecutive cycles.
REQ-031 SHALL test: triangle, volume=8, address 0 -> sample -64; address 127 -> sample 63.
REQ-032 SHALL test: square, volume=15, addresses 200 then 10 back-to-back -> samples -120 then 119, with zero_cross=1 on the second only.
REQ-033 SHALL test: mute=1 with any waveform, and volume=0 with mute=0 -> sample=0 with sample_valid still pulsed.
REQ-034 SHALL test: rst pulsed one cycle after an accepted addr_valid -> no sample_valid is produced, and sample=0 after the reset.

Source files
------------

// File: rtl/wave_reader.sv
// rtl/wave_reader.sv - three-stage waveform sample generator (capture, waveform, scale)
// Sine is built from a bit-exact quarter-wave table of round(127*sin(2*pi*i/256)), i = 0..64.
module wave_reader #(
  parameter int AMP_BITS = 4
) (
  input  logic                clk_10k,
  input  logic                rst,
  input  logic [7:0]          address,
  input  logic                addr_valid,
  input  logic [1:0]          wave_sel,
  input  logic [AMP_BITS-1:0] volume,
  input  logic                mute,
  output logic signed [7:0]   sample,
  output logic                sample_valid,
  output logic                zero_cross
);

  localparam int PW = AMP_BITS + 9;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'b00,
    WAVE_SQUARE   = 2'b01,
    WAVE_SAW      = 2'b10,
    WAVE_TRIANGLE = 2'b11
  } wave_e;

  function automatic logic [6:0] sine_quarter(input logic [6:0] idx);
    logic [6:0] v;
    v = 7'd0;
    case (idx)
      7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;    7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;   7'd5:  v = 7'd16;   7'd6:  v = 7'd19;   7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;   7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
      7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;   7'd15: v = 7'd46;
      7'd16: v = 7'd49;   7'd17: v = 7'd51;   7'd18: v = 7'd54;   7'd19: v = 7'd57;
      7'd20: v = 7'd60;   7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
      7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;   7'd27: v = 7'd78;
      7'd28: v = 7'd81;   7'd29: v = 7'd83;   7'd30: v = 7'd85;   7'd31: v = 7'd88;
      7'd32: v = 7'd90;   7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
      7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;  7'd39: v = 7'd104;
      7'd40: v = 7'd106;  7'd41: v = 7'd107;  7'd42: v = 7'd109;  7'd43: v = 7'd111;
      7'd44: v = 7'd112;  7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
      7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;  7'd51: v = 7'd121;
      7'd52: v = 7'd122;  7'd53: v = 7'd122;  7'd54: v = 7'd123;  7'd55: v = 7'd124;
      7'd56: v = 7'd125;  7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
      7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;  7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Capture stage
  logic [7:0]          addr_q;
  wave_e               sel_q;
  logic [AMP_BITS-1:0] vol1_q;
  logic                mute1_q;
  logic                v1_q;

  // Waveform stage
  logic signed [7:0]   raw_q, raw_d;
  logic [AMP_BITS-1:0] vol2_q;
  logic                mute2_q;
  logic                v2_q;

  // Scale stage
  logic signed [7:0]   sample_q, sample_d;
  logic                valid_q;
  logic                zc_q, zc_d;
  logic                prev_neg_q, prev_neg_d;

  logic [6:0]          sine_idx;
  logic [6:0]          sine_mag;
  logic [6:0]          tri_f;
  logic signed [PW-1:0] raw_ext, vol_ext, prod;
  logic signed [7:0]   scaled;

  always_comb begin
    raw_d    = '0;
    sine_idx = addr_q[6] ? (7'd64 - {1'b0, addr_q[5:0]}) : {1'b0, addr_q[5:0]};
    sine_mag = sine_quarter(sine_idx);
    tri_f    = addr_q[7] ? ~addr_q[6:0] : addr_q[6:0];
    case (sel_q)
      WAVE_SINE:     raw_d = addr_q[7] ? -$signed({1'b0, sine_mag}) : $signed({1'b0, sine_mag});
      WAVE_SQUARE:   raw_d = addr_q[7] ? -8'sd127 : 8'sd127;
      WAVE_SAW:      raw_d = $signed(addr_q ^ 8'h80);
      WAVE_TRIANGLE: raw_d = $signed({tri_f, 1'b0} ^ 8'h80);
      default:       raw_d = '0;
    endcase
  end

  // Arithmetic shift of the full-width product is a floor divide by 16.
  always_comb begin
    raw_ext = {{(PW-8){raw_q[7]}}, raw_q};
    vol_ext = $signed({{(PW-AMP_BITS){1'b0}}, vol2_q});
    prod    = raw_ext * vol_ext;
    scaled  = 8'(prod >>> 4);
    if (mute2_q || (vol2_q == '0)) begin
      scaled = '0;
    end
  end

  always_comb begin
    sample_d   = sample_q;
    prev_neg_d = prev_neg_q;
    zc_d       = 1'b0;
    if (v2_q) begin
      sample_d   = scaled;
      prev_neg_d = scaled[7];
      zc_d       = prev_neg_q && !scaled[7];
    end
  end

  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      sel_q      <= WAVE_SINE;
      vol1_q     <= '0;
      mute1_q    <= 1'b0;
      v1_q       <= 1'b0;
      raw_q      <= '0;
      vol2_q     <= '0;
      mute2_q    <= 1'b0;
      v2_q       <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      zc_q       <= 1'b0;
      prev_neg_q <= 1'b0;
    end else begin
      v1_q <= addr_valid;
      if (addr_valid) begin
        addr_q  <= address;
        sel_q   <= wave_e'(wave_sel);
        vol1_q  <= volume;
        mute1_q <= mute;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        raw_q   <= raw_d;
        vol2_q  <= vol1_q;
        mute2_q <= mute1_q;
      end
      sample_q   <= sample_d;
      valid_q    <= v2_q;
      zc_q       <= zc_d;
      prev_neg_q <= prev_neg_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign zero_cross   = zc_q;

endmodule

// File: tb/tb_wave_reader.sv
// tb/tb_wave_reader.sv - directed self-checking bench for wave_reader
module tb_wave_reader;

  logic              clk_10k;
  logic              rst;
  logic [7:0]        address;
  logic              addr_valid;
  logic [1:0]        wave_sel;
  logic [3:0]        volume;
  logic              mute;
  logic signed [7:0] sample;
  logic              sample_valid;
  logic              zero_cross;

  int checks   = 0;
  int failures = 0;

  wave_reader #(.AMP_BITS(4)) dut (
    .clk_10k      (clk_10k),
    .rst          (rst),
    .address      (address),
    .addr_valid   (addr_valid),
    .wave_sel     (wave_sel),
    .volume       (volume),
    .mute         (mute),
    .sample       (sample),
    .sample_valid (sample_valid),
    .zero_cross   (zero_cross)
  );

  initial clk_10k = 1'b0;
  always #5 clk_10k = ~clk_10k;

  task automatic drive(input logic v, input logic [7:0] a, input logic [1:0] s,
                       input logic [3:0] vol, input logic m);
    @(negedge clk_10k);
    addr_valid = v;
    address    = a;
    wave_sel   = s;
    volume     = vol;
    mute       = m;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 2'b00, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'd64, 2'b00, 4'd15, 1'b0);
    idle();
    idle();
    idle();
    checks++;
    if (sample !== 8'sd0 || sample_valid !== 1'b0 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: sample=%0d valid=%b zc=%b, required 0 0 0", sample, sample_valid, zero_cross);
    end
    rst = 1'b0;
  endtask

  task automatic test_sine();
    drive(1'b1, 8'd64, 2'b00, 4'd15, 1'b0);
    idle();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL sine_early: valid=%b, required 0", sample_valid);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL sine_t1: valid=%b, required 0", sample_valid);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd119 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL sine_64: valid=%b sample=%0d zc=%b, required 1 119 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b0 || sample !== 8'sd119) begin
      failures++;
      $display("FAIL sine_pulse: valid=%b sample=%0d, required 0 119", sample_valid, sample);
    end
  endtask

  task automatic test_saw_wrap();
    drive(1'b1, 8'd255, 2'b10, 4'd15, 1'b0);
    drive(1'b1, 8'd0,   2'b10, 4'd15, 1'b0);
    idle();
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd119 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL saw_255: valid=%b sample=%0d zc=%b, required 1 119 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== -8'sd120 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL saw_0: valid=%b sample=%0d zc=%b, required 1 -120 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL saw_end: valid=%b, required 0", sample_valid);
    end
  endtask

  task automatic test_triangle();
    drive(1'b1, 8'd0,   2'b11, 4'd8, 1'b0);
    drive(1'b1, 8'd127, 2'b11, 4'd8, 1'b0);
    idle();
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== -8'sd64 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL tri_0: valid=%b sample=%0d zc=%b, required 1 -64 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd63 || zero_cross !== 1'b1) begin
      failures++;
      $display("FAIL tri_127: valid=%b sample=%0d zc=%b, required 1 63 1", sample_valid, sample, zero_cross);
    end
  endtask

  task automatic test_back_to_back_square();
    drive(1'b1, 8'd200, 2'b01, 4'd15, 1'b0);
    drive(1'b1, 8'd10,  2'b01, 4'd15, 1'b0);
    idle();
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== -8'sd120 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL sq_200: valid=%b sample=%0d zc=%b, required 1 -120 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd119 || zero_cross !== 1'b1) begin
      failures++;
      $display("FAIL sq_10: valid=%b sample=%0d zc=%b, required 1 119 1", sample_valid, sample, zero_cross);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 8'd200, 2'b01, 4'd15, 1'b0);
    drive(1'b0, 8'd0,   2'b10, 4'd3,  1'b1);
    drive(1'b0, 8'd77,  2'b11, 4'd9,  1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (sample_valid !== 1'b0 || sample !== 8'sd119 || zero_cross !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b sample=%0d zc=%b, required 0 119 0", i, sample_valid, sample, zero_cross);
      end
    end
  endtask

  task automatic test_mute_volume();
    drive(1'b1, 8'd200, 2'b01, 4'd15, 1'b0);
    drive(1'b1, 8'd10,  2'b01, 4'd15, 1'b1);
    drive(1'b1, 8'd64,  2'b00, 4'd0,  1'b0);
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== -8'sd120 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL mv_neg: valid=%b sample=%0d zc=%b, required 1 -120 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd0 || zero_cross !== 1'b1) begin
      failures++;
      $display("FAIL mute: valid=%b sample=%0d zc=%b, required 1 0 1", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd0 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL vol0: valid=%b sample=%0d zc=%b, required 1 0 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL mv_end: valid=%b, required 0", sample_valid);
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 8'd200, 2'b01, 4'd15, 1'b0);
    idle();
    idle();
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== -8'sd120) begin
      failures++;
      $display("FAIL rm_pre: valid=%b sample=%0d, required 1 -120", sample_valid, sample);
    end
    drive(1'b1, 8'd64, 2'b00, 4'd15, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (sample !== 8'sd0 || sample_valid !== 1'b0 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL rm_async: sample=%0d valid=%b zc=%b, required 0 0 0", sample, sample_valid, zero_cross);
    end
    drive(1'b1, 8'd32, 2'b00, 4'd15, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (sample_valid !== 1'b0 || sample !== 8'sd0) begin
        failures++;
        $display("FAIL rm_drop_%0d: valid=%b sample=%0d, required 0 0", i, sample_valid, sample);
      end
    end
    idle();
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'sd84 || zero_cross !== 1'b0) begin
      failures++;
      $display("FAIL rm_first: valid=%b sample=%0d zc=%b, required 1 84 0", sample_valid, sample, zero_cross);
    end
    idle();
    checks++;
    if (sample_valid !== 1'b0 || sample !== 8'sd84) begin
      failures++;
      $display("FAIL rm_end: valid=%b sample=%0d, required 0 84", sample_valid, sample);
    end
  endtask

  initial begin
    rst        = 1'b1;
    address    = 8'd0;
    addr_valid = 1'b0;
    wave_sel   = 2'b00;
    volume     = 4'd0;
    mute       = 1'b0;
    test_reset();
    test_sine();
    test_saw_wrap();
    test_triangle();
    test_back_to_back_square();
    test_hold();
    test_mute_volume();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
